// File: rtl/dit_ifft_8.sv
// 8-point radix-2 DIT inverse FFT: bit-reversed load, three in-place butterfly
// stages (one per clock, each scaled by 1/2), saturated natural-order output.
module dit_ifft_8 #(
    parameter int width = 9
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [8*width-1:0]   xr_i,
    input  logic [8*width-1:0]   xi_i,
    output logic [8*width-1:0]   yr_o,
    output logic [8*width-1:0]   yi_o,
    output logic                 vld,
    output logic                 busy,
    output logic [1:0]           counter_o
);

    typedef logic signed [width+1:0] iv_t;   // stage intermediate
    typedef logic signed [width+2:0] sv_t;   // butterfly sum before the >>>1
    typedef logic signed [width+9:0] pv_t;   // product with the 181/256 constant
    typedef enum logic [1:0] {IDLE = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

    state_t state;
    iv_t    ar [8];
    iv_t    ai [8];
    iv_t    nr [8];
    iv_t    ni [8];

    function automatic logic [2:0] rev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // v / sqrt2 approximated as (v * 181) >>> 8, rounding toward -inf
    function automatic iv_t scale_r2(input iv_t v);
        pv_t p;
        p = pv_t'(v) * pv_t'(181);
        return iv_t'(p >>> 8);
    endfunction

    // Conjugate twiddle product: tw 0 = 1, 1 = (1+j)/sqrt2, 2 = +j, 3 = (-1+j)/sqrt2
    function automatic void twiddle(input iv_t br, input iv_t bi, input logic [1:0] tw,
                                    output sv_t wr, output sv_t wi);
        iv_t tr;
        iv_t ti;
        tr = scale_r2(br);
        ti = scale_r2(bi);
        case (tw)
            2'd0: begin wr = sv_t'(br);                 wi = sv_t'(bi);                end
            2'd1: begin wr = sv_t'(tr) - sv_t'(ti);     wi = sv_t'(tr) + sv_t'(ti);    end
            2'd2: begin wr = -sv_t'(bi);                wi = sv_t'(br);                end
            default: begin wr = -sv_t'(tr) - sv_t'(ti); wi = sv_t'(tr) - sv_t'(ti);   end
        endcase
    endfunction

    function automatic iv_t half(input sv_t s);
        return iv_t'(s >>> 1);
    endfunction

    function automatic logic [width-1:0] sat(input iv_t v);
        if (v > iv_t'((1 << (width - 1)) - 1))
            return {1'b0, {(width-1){1'b1}}};
        else if (v < -iv_t'(1 << (width - 1)))
            return {1'b1, {(width-1){1'b0}}};
        else
            return v[width-1:0];
    endfunction

    // One butterfly stage over all 8 points; span and twiddle stride follow the state
    always_comb begin
        int  h;
        int  sh;
        int  b;
        sv_t wr;
        sv_t wi;
        nr = ar;
        ni = ai;
        h  = 1;
        sh = 2;
        b  = 0;
        wr = '0;
        wi = '0;
        case (state)
            S2:      begin h = 2; sh = 1; end
            S3:      begin h = 4; sh = 0; end
            default: begin h = 1; sh = 2; end
        endcase
        for (int k = 0; k < 8; k++) begin
            if ((k & h) == 0) begin
                b = k + h;
                twiddle(ar[b], ai[b], 2'((k & (h - 1)) << sh), wr, wi);
                nr[k] = half(sv_t'(ar[k]) + wr);
                ni[k] = half(sv_t'(ai[k]) + wi);
                nr[b] = half(sv_t'(ar[k]) - wr);
                ni[b] = half(sv_t'(ai[k]) - wi);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ar    <= '{default: '0};
            ai    <= '{default: '0};
            yr_o  <= '0;
            yi_o  <= '0;
            vld   <= 1'b0;
        end else begin
            vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 8; k++) begin
                            ar[k] <= iv_t'($signed(xr_i[rev3(3'(k))*width +: width]));
                            ai[k] <= iv_t'($signed(xi_i[rev3(3'(k))*width +: width]));
                        end
                        state <= S1;
                    end
                end
                S1: begin
                    ar    <= nr;
                    ai    <= ni;
                    state <= S2;
                end
                S2: begin
                    ar    <= nr;
                    ai    <= ni;
                    state <= S3;
                end
                default: begin
                    ar <= nr;
                    ai <= ni;
                    for (int k = 0; k < 8; k++) begin
                        yr_o[k*width +: width] <= sat(nr[k]);
                        yi_o[k*width +: width] <= sat(ni[k]);
                    end
                    vld   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign counter_o = state;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dit_ifft_8.sv
// Directed bench for dit_ifft_8: hand-computed spectra/time samples, latency,
// back-to-back throughput and mid-transform reset.
module tb_dit_ifft_8;
    localparam int W  = 9;
    localparam int VW = 8 * W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [VW-1:0] xr_i = '0;
    logic [VW-1:0] xi_i = '0;
    logic [VW-1:0] yr_o;
    logic [VW-1:0] yi_o;
    logic          vld;
    logic          busy;
    logic [1:0]    counter_o;

    dit_ifft_8 #(.width(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .xr_i(xr_i), .xi_i(xi_i),
        .yr_o(yr_o), .yi_o(yi_o), .vld(vld), .busy(busy), .counter_o(counter_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*VW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack8(input int v[8]);
        logic [VW-1:0] p;
        logic [31:0]   t;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            t = v[k];
            p[k*W +: W] = t[W-1:0];
        end
        return p;
    endfunction

    function automatic logic [VW-1:0] rep8(input int v);
        int a[8];
        for (int k = 0; k < 8; k++) a[k] = v;
        return pack8(a);
    endfunction

    // One transform from IDLE: latency, pulse width and held result
    task automatic run(input string tag, input logic [VW-1:0] xr, input logic [VW-1:0] xi,
                       input logic [VW-1:0] eyr, input logic [VW-1:0] eyi);
        xr_i = xr;
        xi_i = xi;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_cnt1"}, VW'(counter_o), VW'(1));
        check({tag, "_busy1"}, VW'(busy), VW'(1));
        check({tag, "_vld1"}, VW'(vld), VW'(0));
        @(posedge clk); #1;
        check({tag, "_cnt2"}, VW'(counter_o), VW'(2));
        check({tag, "_vld2"}, VW'(vld), VW'(0));
        @(posedge clk); #1;
        check({tag, "_cnt3"}, VW'(counter_o), VW'(3));
        check({tag, "_vld3"}, VW'(vld), VW'(0));
        @(posedge clk); #1;
        check({tag, "_vld"}, VW'(vld), VW'(1));
        check({tag, "_busy0"}, VW'(busy), VW'(0));
        check({tag, "_yr"}, yr_o, eyr);
        check({tag, "_yi"}, yi_o, eyi);
        @(posedge clk); #1;
        check({tag, "_vld_pulse"}, VW'(vld), VW'(0));
        check({tag, "_yr_hold"}, yr_o, eyr);
    endtask

    logic [VW-1:0] imp_x, imp_y, dc_x, dc_y, neg_x, neg_y, tone_x, tone_yr, tone_yi;
    logic [VW-1:0] pat_x[3];
    logic [VW-1:0] pat_y[3];
    logic [2*VW-1:0] e;
    logic [95:0] rnd;
    int v[8];

    initial begin
        v = '{8, 0, 0, 0, 0, 0, 0, 0};           imp_x = pack8(v);
        imp_y = rep8(1);
        dc_x = rep8(8);                          dc_y = imp_x;
        v = '{-256, 0, 0, 0, 0, 0, 0, 0};        neg_x = pack8(v);
        neg_y = rep8(-32);
        v = '{0, 64, 0, 0, 0, 0, 0, 0};          tone_x = pack8(v);
        v = '{8, 5, 0, -6, -8, -6, 0, 5};        tone_yr = pack8(v);
        v = '{0, 5, 8, 5, 0, -6, -8, -6};        tone_yi = pack8(v);
        pat_x = '{imp_x, dc_x, neg_x};
        pat_y = '{imp_y, dc_y, neg_y};

        repeat (2) @(posedge clk);
        #1;
        check("rst_yr", yr_o, '0);
        check("rst_yi", yi_o, '0);
        check("rst_vld", VW'(vld), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_cnt", VW'(counter_o), VW'(0));
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_cnt", VW'(counter_o), VW'(0));

        run("t1_impulse", imp_x, '0, imp_y, '0);
        run("t2_dc", dc_x, '0, dc_y, '0);
        run("t3_tone", tone_x, '0, tone_yr, tone_yi);
        run("t4_negfs", neg_x, '0, neg_y, '0);
        v = '{-256, 0, 0, 0, 0, 0, 0, 0};
        run("t4_neg_dc", rep8(-256), '0, pack8(v), '0);
        v = '{255, 0, 0, 0, 0, 0, 0, 0};
        run("t4_pos_dc", rep8(255), '0, pack8(v), '0);
        run("t4_imag", '0, imp_x, '0, imp_y);

        // Back-to-back: start held high, inputs scrambled while busy
        start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c % 4 == 0) begin
                xr_i = pat_x[c / 4];
                xi_i = '0;
                exp_q.push_back({pat_y[c / 4], VW'(0)});
            end else begin
                rnd = {$urandom, $urandom, $urandom};
                xr_i = rnd[VW-1:0];
                rnd = {$urandom, $urandom, $urandom};
                xi_i = rnd[VW-1:0];
            end
            @(posedge clk); #1;
            check("t5_cnt", VW'(counter_o), VW'((c % 4 + 1) % 4));
            check("t5_vld", VW'(vld), VW'(c % 4 == 3));
            if (vld) begin
                if (exp_q.size() == 0) begin
                    check("t5_unexpected_vld", VW'(1), VW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("t5_yr", yr_o, e[2*VW-1:VW]);
                    check("t5_yi", yi_o, e[VW-1:0]);
                end
            end
        end
        start = 1'b0;
        check("t5_q_empty", VW'(exp_q.size()), VW'(0));

        // Reset in stage 2 discards the transform
        xr_i = dc_x;
        xi_i = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8 && counter_o != 2'd2; i++) begin
            @(posedge clk); #1;
        end
        check("t6_reached_s2", VW'(counter_o), VW'(2));
        rstn = 1'b0;
        #1;
        check("t6_yr", yr_o, '0);
        check("t6_yi", yi_o, '0);
        check("t6_cnt", VW'(counter_o), VW'(0));
        check("t6_busy", VW'(busy), VW'(0));
        check("t6_vld", VW'(vld), VW'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t6_no_vld", VW'(vld), VW'(0));
            check("t6_idle", VW'(counter_o), VW'(0));
        end
        run("t6_after", imp_x, '0, imp_y, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
